// File: rtl/fp_div_pkg.sv
// Shared single-precision field definitions for the divider.
// It also provides field-extract helpers and the constant result patterns.
package fp_div_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
  localparam int M_W   = MAN_W + 1;          // mantissa including the hidden one
  localparam int Q_W   = MAN_W + 2;          // quotient bits produced per divide
  localparam int E_W   = EXP_W + 2;          // signed working exponent
  localparam int CNT_W = $clog2(Q_W + 1);

  localparam logic [EXP_W-1:0] EXP_MAX  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [W-2:0]     FP_ZERO  = {(W - 1){1'b0}};
  localparam logic [W-2:0]     FP_INF   = {EXP_MAX, {MAN_W{1'b0}}};

  function automatic logic f_sign(input logic [W-1:0] x);
    return x[W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
    return x[W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface fp_div_if;
  import fp_div_pkg::*;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] C;

  modport master (output start, output A, output B, input busy, input done, input C);
  modport slave  (input start, input A, input B, output busy, output done, output C);

endinterface

// File: rtl/fp_div_core.sv
// Restoring shift-subtract mantissa divider producing one quotient bit per step.
// The remainder stays below 2*mB, so one bit above the mantissa width is enough.
module fp_div_core
  import fp_div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [M_W-1:0] i_ma,
  input  logic [M_W-1:0] i_mb,
  output logic [Q_W-1:0] o_q,
  output logic           o_last
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Q_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

  logic [M_W:0]     r_rem;
  logic [M_W-1:0]   r_mb;
  logic [Q_W-1:0]   r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [M_W:0]     w_diff;
  logic [M_W:0]     w_rem_nxt;
  logic             w_ge;

  // Trial subtraction and next remainder.
  always_comb begin
    w_diff = r_rem - {1'b0, r_mb};
    w_ge   = (r_rem >= {1'b0, r_mb});
    if (w_ge) begin
      w_rem_nxt = {w_diff[M_W-1:0], 1'b0};
    end else begin
      w_rem_nxt = {r_rem[M_W-1:0], 1'b0};
    end
  end

  // Remainder, divisor, quotient and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem <= {(M_W + 1){1'b0}};
      r_mb  <= {M_W{1'b0}};
      r_q   <= {Q_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_rem <= {1'b0, i_ma};
      r_mb  <= i_mb;
      r_q   <= {Q_W{1'b0}};
      r_cnt <= CNT_INIT;
    end else if (i_step) begin
      r_rem <= w_rem_nxt;
      r_q   <= {r_q[Q_W-2:0], w_ge};
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_q    = r_q;
  assign o_last = (r_cnt == CNT_ONE);

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider C = A / B with truncation and zero flush.
// Special operands take a single NORM cycle, so done still rises one edge after acceptance.
module fp_div
  import fp_div_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  fp_div_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [E_W-1:0] EXP_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EXP_OVF  = {2'b00, EXP_MAX};
  localparam logic signed [E_W-1:0] EXP_NONE = {E_W{1'b0}};
  localparam logic signed [E_W-1:0] EXP_ONE  = {{(E_W - 1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_busy;
  logic                   r_done;
  logic [W-1:0]           r_c;
  logic                   r_sign;
  logic                   r_special;
  logic [W-2:0]           r_spec_mag;
  logic signed [E_W-1:0]  r_exp;

  logic                   w_accept;
  logic                   w_a_zero;
  logic                   w_special;
  logic [W-2:0]           w_spec_mag;
  logic signed [E_W-1:0]  w_exp_cap;
  logic signed [E_W-1:0]  w_exp_n;
  logic [MAN_W-1:0]       w_man;
  logic [W-2:0]           w_c_mag;
  logic [Q_W-1:0]         w_q;
  logic                   w_last;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_a_zero   = (f_exp(bus.A) == EXP_ZERO);
  assign w_special  = w_a_zero || (f_exp(bus.B) == EXP_ZERO);
  assign w_spec_mag = w_a_zero ? FP_ZERO : FP_INF;
  assign w_exp_cap  = $signed({2'b00, f_exp(bus.A)}) - $signed({2'b00, f_exp(bus.B)}) + EXP_BIAS;

  fp_div_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept && !w_special),
    .i_step (r_state == S_DIV),
    .i_ma   ({1'b1, f_man(bus.A)}),
    .i_mb   ({1'b1, f_man(bus.B)}),
    .o_q    (w_q),
    .o_last (w_last)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_special) begin
            w_state_nxt = S_NORM;
          end else begin
            w_state_nxt = S_DIV;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_NORM;
        end else begin
          w_state_nxt = S_DIV;
        end
      end
      S_NORM:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A quotient below one (mA < mB) needs one more shift and an exponent decrement.
  always_comb begin
    if (w_q[Q_W-1]) begin
      w_man   = w_q[Q_W-2 -: MAN_W];
      w_exp_n = r_exp;
    end else begin
      w_man   = w_q[Q_W-3 -: MAN_W];
      w_exp_n = r_exp - EXP_ONE;
    end
    if (r_special) begin
      w_c_mag = r_spec_mag;
    end else if (w_exp_n >= EXP_OVF) begin
      w_c_mag = FP_INF;
    end else if (w_exp_n <= EXP_NONE) begin
      w_c_mag = FP_ZERO;
    end else begin
      w_c_mag = {w_exp_n[EXP_W-1:0], w_man};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_c        <= {W{1'b0}};
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_mag <= FP_ZERO;
      r_exp      <= EXP_NONE;
    end else begin
      r_busy <= (w_state_nxt == S_DIV) || (w_state_nxt == S_NORM);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_sign     <= f_sign(bus.A) ^ f_sign(bus.B);
        r_special  <= w_special;
        r_spec_mag <= w_spec_mag;
        r_exp      <= w_exp_cap;
      end
      if (r_state == S_NORM) begin
        r_c <= {r_sign, w_c_mag};
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.C    = r_c;

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: arithmetic reference model plus a per-cycle checker
// of busy, done and C against the expected handshake timing.
module tb_fp_div;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  fp_div_if bus ();

  fp_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          chk_en  = 1'b0;
  bit          pending = 1'b0;
  int          acc     = 0;
  int          lat     = 0;
  logic [31:0] exp_c   = 32'h0;
  logic [31:0] last_c  = 32'h0;
  int          cmp_d;
  logic        cmp_eb;
  logic        cmp_ed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference quotient from the real-valued mantissa ratio, truncated.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, q;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return {s, 31'd0};
    if (eb == 0) return {s, 8'hFF, 23'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    q  = (ma << 23) / mb;
    if (q < (longint'(1) << 23)) begin
      q = (ma << 24) / mb;
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // Per-cycle comparison of the handshake and result against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_eb = 1'b0;
      cmp_ed = 1'b0;
      if (pending) begin
        cmp_d  = cyc - acc;
        cmp_eb = (cmp_d < lat);
        cmp_ed = (cmp_d == lat);
      end
      check("busy", {31'd0, bus.busy}, {31'd0, cmp_eb});
      check("done", {31'd0, bus.done}, {31'd0, cmp_ed});
      if (cmp_ed) begin
        check("C", bus.C, exp_c);
        last_c  = exp_c;
        pending = 1'b0;
      end else begin
        check("C_hold", bus.C, last_c);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    acc       = cyc;
    exp_c     = model(a, b);
    lat       = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 26;
    pending   = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pending && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (pending) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done not seen within 60 cycles (cycle %0d)", cyc);
      pending = 1'b0;
    end
  endtask

  task automatic run_lit(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    check("model_pin", model(a, b), want);
    issue(a, b);
    wait_done();
  endtask

  task automatic run_mod(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_lit(32'h40C00000, 32'h40000000, 32'h40400000);
    run_lit(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    run_lit(32'hBF800000, 32'h40800000, 32'hBE800000);
    run_lit(32'h3F800000, 32'h00000000, 32'h7F800000);
    run_lit(32'h00000000, 32'h40A00000, 32'h00000000);
    run_lit(32'h00000000, 32'h00000000, 32'h00000000);
    run_lit(32'h80000000, 32'h40000000, 32'h80000000);
    run_lit(32'h3F800000, 32'h80000000, 32'hFF800000);
    run_lit(32'h7F000000, 32'h3E800000, 32'h7F800000);
    run_lit(32'h00800000, 32'h7F000000, 32'h00000000);
    run_mod(32'h40490FDB, 32'h402DF854);
    run_mod(32'h40E00000, 32'hC0400000);
    run_mod(32'h3F7FFFFF, 32'h3F800001);
    run_mod(32'h4B7FFFFF, 32'h3F800001);

    // A start at edge 5 while busy must be ignored.
    issue(32'h3F800000, 32'h40400000);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    check("ignored_start_C", last_c, 32'h3EAAAAAA);
    repeat (30) begin
      @(posedge clk); #1;
    end

    // Reset at edge 10 aborts the division; no done may follow.
    issue(32'h40C00000, 32'h40000000);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    pending = 1'b0;
    last_c  = 32'h0;
    rst_n   = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
    end

    run_lit(32'h40C00000, 32'h40000000, 32'h40400000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
